vdp_host_port: RTL and testbench

CPU-facing register port that drives the VDP write interface (`write_data`, `write_addr[13:0]`, `write_enable`) in the `write_clk` domain. The CPU loads a 14-bit VRAM address pointer and streams data bytes through a single data register, and the pointer auto-increments after each byte. A hardware fill engine writes a repeated byte COUNT times without CPU involvement. The block sits directly upstream of `vdp`: its `vdp_*` outputs connect straight to the VDP write port.

---
 rtl/vdp_host_port.sv | 146 ++++++++++++++
 tb/tb_vdp_host_port.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vdp_host_port.sv
// CPU register port feeding the VDP write interface: auto-incrementing VRAM
// pointer, single-byte data writes and a hardware fill engine.
module vdp_host_port (
  input  logic        write_clk,
  input  logic        reset,
  input  logic        cpu_cs,
  input  logic        cpu_we,
  input  logic [2:0]  cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        busy,
  output logic [13:0] vdp_addr,
  output logic [7:0]  vdp_data,
  output logic        vdp_we
);

  typedef enum logic {
    S_IDLE,
    S_FILL
  } state_t;

  state_t      state, state_nx;
  logic [13:0] ptr, ptr_nx;
  logic [13:0] cnt, cnt_nx;
  logic [7:0]  incr, incr_nx;
  logic [7:0]  fill_val, fill_val_nx;
  logic        ovr, ovr_nx;
  logic [7:0]  rdata_nx;
  logic        busy_nx;
  logic [13:0] vaddr_nx;
  logic [7:0]  vdata_nx;
  logic        we_nx;
  logic        wr_acc;
  logic        rd_acc;
  logic [13:0] ptr_inc;

  // State and registered outputs; reset aborts any fill in progress.
  always_ff @(posedge write_clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      ptr       <= '0;
      cnt       <= '0;
      incr      <= 8'd1;
      fill_val  <= '0;
      ovr       <= 1'b0;
      cpu_rdata <= '0;
      busy      <= 1'b0;
      vdp_addr  <= '0;
      vdp_data  <= '0;
      vdp_we    <= 1'b0;
    end else begin
      state     <= state_nx;
      ptr       <= ptr_nx;
      cnt       <= cnt_nx;
      incr      <= incr_nx;
      fill_val  <= fill_val_nx;
      ovr       <= ovr_nx;
      cpu_rdata <= rdata_nx;
      busy      <= busy_nx;
      vdp_addr  <= vaddr_nx;
      vdp_data  <= vdata_nx;
      vdp_we    <= we_nx;
    end
  end

  // Next-state, register updates, read mux and VDP write generation.
  always_comb begin
    state_nx    = state;
    ptr_nx      = ptr;
    cnt_nx      = cnt;
    incr_nx     = incr;
    fill_val_nx = fill_val;
    ovr_nx      = ovr;
    rdata_nx    = cpu_rdata;
    busy_nx     = 1'b0;
    vaddr_nx    = vdp_addr;
    vdata_nx    = vdp_data;
    we_nx       = 1'b0;
    wr_acc      = cpu_cs & cpu_we;
    rd_acc      = cpu_cs & ~cpu_we;
    ptr_inc     = ptr + {6'b0, incr};

    if (rd_acc) begin
      case (cpu_addr)
        3'd0:    rdata_nx = ptr[7:0];
        3'd1:    rdata_nx = {2'b00, ptr[13:8]};
        3'd3:    rdata_nx = incr;
        3'd4:    rdata_nx = cnt[7:0];
        3'd5:    rdata_nx = {2'b00, cnt[13:8]};
        default: begin
          rdata_nx = {busy, ovr, 6'b0};
          ovr_nx   = 1'b0;
        end
      endcase
    end

    case (state)
      S_IDLE: begin
        if (wr_acc) begin
          case (cpu_addr)
            3'd0: ptr_nx  = {ptr[13:8], cpu_wdata};
            3'd1: ptr_nx  = {cpu_wdata[5:0], ptr[7:0]};
            3'd2: begin
              we_nx    = 1'b1;
              vaddr_nx = ptr;
              vdata_nx = cpu_wdata;
              ptr_nx   = ptr_inc;
            end
            3'd3: incr_nx = cpu_wdata;
            3'd4: cnt_nx  = {cnt[13:8], cpu_wdata};
            3'd5: cnt_nx  = {cpu_wdata[5:0], cnt[7:0]};
            3'd6: begin
              // The first fill byte is issued on the starting edge so the
              // pulse train lines up with busy; a single-byte fill never
              // needs to enter S_FILL.
              if (cnt != '0) begin
                fill_val_nx = cpu_wdata;
                we_nx       = 1'b1;
                busy_nx     = 1'b1;
                vaddr_nx    = ptr;
                vdata_nx    = cpu_wdata;
                ptr_nx      = ptr_inc;
                cnt_nx      = cnt - 14'd1;
                if (cnt != 14'd1) state_nx = S_FILL;
              end
            end
            default: ;
          endcase
        end
      end
      S_FILL: begin
        we_nx    = 1'b1;
        busy_nx  = 1'b1;
        vaddr_nx = ptr;
        vdata_nx = fill_val;
        ptr_nx   = ptr_inc;
        cnt_nx   = cnt - 14'd1;
        if (cnt == 14'd1) state_nx = S_IDLE;
        // Placed after the STATUS read clear so a coincident set wins.
        if (wr_acc) ovr_nx = 1'b1;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_vdp_host_port.sv
// Self-checking bench for vdp_host_port: directed scenarios plus random
// register traffic, all compared cycle by cycle against a behavioural model.
module tb_vdp_host_port;

  logic        write_clk = 1'b0;
  logic        reset     = 1'b0;
  logic        cpu_cs    = 1'b0;
  logic        cpu_we    = 1'b0;
  logic [2:0]  cpu_addr  = '0;
  logic [7:0]  cpu_wdata = '0;
  logic [7:0]  cpu_rdata;
  logic        busy;
  logic [13:0] vdp_addr;
  logic [7:0]  vdp_data;
  logic        vdp_we;

  vdp_host_port dut (
    .write_clk (write_clk),
    .reset     (reset),
    .cpu_cs    (cpu_cs),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .busy      (busy),
    .vdp_addr  (vdp_addr),
    .vdp_data  (vdp_data),
    .vdp_we    (vdp_we)
  );

  always #5 write_clk = ~write_clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model: architectural registers plus a description of the fill
  // in flight (start pointer, step, length, index of the next byte).
  int unsigned m_ptr, m_incr, m_cnt, m_ovr;
  int unsigned fb_p, fb_i, fb_n, fb_j, fb_left;
  int unsigned e_busy, e_we, e_rdata, e_vaddr, e_vdata;
  int unsigned q_addr[$];
  int unsigned q_data[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input bit rst_n, input bit cs, input bit we,
                            input logic [2:0] a, input logic [7:0] wd);
    bit          filling;
    int unsigned cur_ptr, cur_cnt, d, new_busy;
    if (!rst_n) begin
      m_ptr = 0; m_incr = 1; m_cnt = 0; m_ovr = 0;
      fb_left = 0; fb_j = 0;
      e_busy = 0; e_we = 0; e_rdata = 0; e_vaddr = 0; e_vdata = 0;
      q_addr.delete(); q_data.delete();
      return;
    end
    d        = int'(wd);
    filling  = (fb_left > 0);
    cur_ptr  = filling ? (fb_p + fb_j * fb_i) % 16384 : m_ptr;
    cur_cnt  = filling ? fb_n - fb_j : m_cnt;
    new_busy = 0;
    e_we     = 0;

    if (cs && !we) begin
      case (a)
        3'd0: e_rdata = cur_ptr % 256;
        3'd1: e_rdata = cur_ptr / 256;
        3'd3: e_rdata = m_incr;
        3'd4: e_rdata = cur_cnt % 256;
        3'd5: e_rdata = cur_cnt / 256;
        default: begin
          e_rdata = e_busy * 128 + m_ovr * 64;
          m_ovr   = 0;
        end
      endcase
    end

    if (filling) begin
      if (cs && we) m_ovr = 1;
      fb_j++;
      fb_left--;
      e_we = 1;
      new_busy = 1;
    end else if (cs && we) begin
      case (a)
        3'd0: m_ptr = (m_ptr / 256) * 256 + d;
        3'd1: m_ptr = (d % 64) * 256 + m_ptr % 256;
        3'd2: begin
          q_addr.push_back(m_ptr);
          q_data.push_back(d);
          m_ptr = (m_ptr + m_incr) % 16384;
          e_we  = 1;
        end
        3'd3: m_incr = d;
        3'd4: m_cnt = (m_cnt / 256) * 256 + d;
        3'd5: m_cnt = (d % 64) * 256 + m_cnt % 256;
        3'd6: begin
          if (m_cnt != 0) begin
            for (int unsigned k = 0; k < m_cnt; k++) begin
              q_addr.push_back((m_ptr + k * m_incr) % 16384);
              q_data.push_back(d);
            end
            fb_p = m_ptr; fb_i = m_incr; fb_n = m_cnt;
            fb_j = 1; fb_left = m_cnt - 1;
            m_ptr = (m_ptr + m_cnt * m_incr) % 16384;
            m_cnt = 0;
            e_we = 1;
            new_busy = 1;
          end
        end
        default: ;
      endcase
    end
    e_busy = new_busy;
    if (e_we != 0) begin
      if (q_addr.size() == 0) begin
        check("model_queue_empty", 32'd1, 32'd0);
      end else begin
        e_vaddr = q_addr.pop_front();
        e_vdata = q_data.pop_front();
      end
    end
  endtask

  task automatic check_outputs();
    check("vdp_we",    32'(vdp_we),    e_we);
    check("vdp_addr",  32'(vdp_addr),  e_vaddr);
    check("vdp_data",  32'(vdp_data),  e_vdata);
    check("busy",      32'(busy),      e_busy);
    check("cpu_rdata", 32'(cpu_rdata), e_rdata);
  endtask

  // One clock: drive at the falling edge, model the rising edge, check at the
  // next falling edge.
  task automatic step(input bit rst_n, input bit cs, input bit we,
                      input logic [2:0] a, input logic [7:0] wd);
    reset     = rst_n;
    cpu_cs    = cs;
    cpu_we    = we;
    cpu_addr  = a;
    cpu_wdata = wd;
    model_edge(rst_n, cs, we, a, wd);
    @(negedge write_clk);
    check_outputs();
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    step(1'b1, 1'b1, 1'b1, a, d);
  endtask

  task automatic rd(input logic [2:0] a);
    step(1'b1, 1'b1, 1'b0, a, 8'h00);
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
  endtask

  task automatic wait_not_busy();
    int unsigned n = 0;
    while (busy && n < 20000) begin
      idle();
      n++;
    end
    check("fill_done_bound", 32'(busy), 32'd0);
  endtask

  initial begin
    int unsigned b;
    logic [2:0]  ra;
    logic [7:0]  rd_v;
    bit          rwe;

    @(negedge write_clk);
    step(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);

    // Reset values.
    rd(3'd3);
    check("rst_incr", 32'(cpu_rdata), 32'h01);
    rd(3'd7);
    check("rst_status", 32'(cpu_rdata), 32'h00);
    check("rst_vdp_addr", 32'(vdp_addr), 32'h0);

    // Back-to-back DATA writes across the pointer wrap.
    wr(3'd0, 8'hFE);
    wr(3'd1, 8'hFF);
    wr(3'd3, 8'h01);
    wr(3'd2, 8'hAA);
    check("wrap_addr0", 32'(vdp_addr), 32'h3FFE);
    wr(3'd2, 8'hBB);
    check("wrap_addr1", 32'(vdp_addr), 32'h3FFF);
    wr(3'd2, 8'hCC);
    check("wrap_addr2", 32'(vdp_addr), 32'h0000);
    check("wrap_data2", 32'(vdp_data), 32'hCC);
    idle();
    rd(3'd0);
    check("wrap_ptr_lo", 32'(cpu_rdata), 32'h01);
    rd(3'd1);
    check("wrap_ptr_hi", 32'(cpu_rdata), 32'h00);

    // Four-byte fill with stride 2.
    wr(3'd0, 8'h00);
    wr(3'd1, 8'h10);
    wr(3'd3, 8'h02);
    wr(3'd4, 8'h04);
    wr(3'd5, 8'h00);
    wr(3'd6, 8'h55);
    b = 0;
    while (busy && b < 50) begin
      b++;
      idle();
    end
    check("fill4_busy_len", b, 32'd4);
    rd(3'd0);
    check("fill4_ptr_lo", 32'(cpu_rdata), 32'h08);
    rd(3'd1);
    check("fill4_ptr_hi", 32'(cpu_rdata), 32'h10);
    rd(3'd4);
    check("fill4_cnt", 32'(cpu_rdata), 32'h00);

    // Zero-length fill is a no-op.
    wr(3'd4, 8'h00);
    wr(3'd6, 8'h11);
    check("fill0_we", 32'(vdp_we), 32'd0);
    idle();
    check("fill0_busy", 32'(busy), 32'd0);

    // Write during a long fill is dropped and flagged.
    wr(3'd3, 8'h01);
    wr(3'd4, 8'd100);
    wr(3'd6, 8'h3C);
    idle();
    idle();
    wr(3'd2, 8'h77);
    rd(3'd2);
    check("ovr_status_busy", 32'(cpu_rdata), 32'hC0);
    wait_not_busy();
    rd(3'd6);
    check("ovr_status_clear", 32'(cpu_rdata), 32'h00);

    // Reset in the middle of a fill.
    wr(3'd1, 8'h02);
    wr(3'd4, 8'd100);
    wr(3'd6, 8'hE1);
    for (int i = 0; i < 9; i++) idle();
    step(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    check("rstfill_we", 32'(vdp_we), 32'd0);
    check("rstfill_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 3; i++) idle();
    rd(3'd0);
    check("rstfill_ptr_lo", 32'(cpu_rdata), 32'h00);
    rd(3'd1);
    check("rstfill_ptr_hi", 32'(cpu_rdata), 32'h00);

    // Random register traffic; fill lengths kept short via COUNT_HI.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        step(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
      end else if ($urandom_range(0, 3) == 0) begin
        idle();
      end else begin
        ra   = 3'($urandom_range(0, 7));
        rwe  = 1'($urandom_range(0, 1));
        rd_v = 8'($urandom);
        if (ra == 3'd5 && rwe) rd_v = 8'($urandom_range(0, 1)) | (8'($urandom_range(0, 3)) << 6);
        if (ra == 3'd4 && rwe && $urandom_range(0, 3) == 0) rd_v = 8'h00;
        step(1'b1, 1'b1, rwe, ra, rd_v);
      end
    end
    wait_not_busy();
    idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
